// File: rtl/ysyx_22050058_div_pkg.sv
// Shared definitions for the iterative divider.
//   ST_*         : FSM state encodings (IDLE/BUSY/FIX/DONE)
//   cnt_width()  : width of the BUSY iteration counter for a given WIDTH
//   steps_legal(): legality of the STEPS parameter for a given WIDTH
package ysyx_22050058_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Counter is loaded with N-1, at most WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic bit steps_legal(input int width, input int steps);
        return (steps == 1 || steps == 2 || steps == 4) &&
               (width >= 8) && (width % 2 == 0) &&
               ((width / 2) % steps == 0);
    endfunction

endpackage

// File: rtl/ysyx_22050058_div_step.sv
// One restoring division step (combinational).
//   rem_in  : partial remainder, always < div
//   div     : divisor magnitude (non-zero)
//   q_in    : shift register; MSB is the next dividend bit, LSB side collects quotient bits
//   rem_out : updated partial remainder
//   q_out   : q_in shifted left with the new quotient bit in the LSB
module ysyx_22050058_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] div,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // With rem_in < div the shifted value is < 2*div, so the borrow bit of
    // the WIDTH+1 bit subtraction alone tells whether shifted >= div.
    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        diff    = shifted - {1'b0, div};
        ge      = ~diff[WIDTH];
        rem_out = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/ysyx_22050058_div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned, full width and
// half-width word ops, RISC-V divide-by-zero / overflow results).
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync abort)
//   in_valid_i / in_ready_o, signed_i, word_i, dividend_i, divisor_i : request
//   out_valid_o / out_ready_i, quotient_o, remainder_o                : response
// Optional feature: define YSYX_22050058_DIV_FASTPATH_EN to finish with a
// 1-cycle latency when |dividend| < |divisor|.
module ysyx_22050058_div_iter
    import ysyx_22050058_div_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEPS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             signed_i,
    input  logic             word_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int H  = WIDTH / 2;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH / STEPS - 1);
    localparam logic [CW-1:0] CNT_WORD = CW'(H / STEPS - 1);

    if (!steps_legal(WIDTH, STEPS)) begin : g_bad_steps
        $error("ysyx_22050058_div_iter: illegal WIDTH/STEPS combination");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             q_neg;
    logic             r_neg;
    logic             word_q;
    logic             bypass;

    assign in_ready_o  = (state == ST_IDLE);
    assign out_valid_o = (state == ST_DONE);

    // Operand conditioning at accept time.
    logic [WIDTH-1:0] a_ext, b_ext, a_sx, a_mag, b_mag;
    logic             a_sgn, b_sgn, a_min, b_m1, special;
    logic [WIDTH-1:0] spec_q, spec_r;

    always_comb begin
        a_ext = word_i ? {{H{signed_i & dividend_i[H-1]}}, dividend_i[H-1:0]} : dividend_i;
        b_ext = word_i ? {{H{signed_i & divisor_i[H-1]}}, divisor_i[H-1:0]} : divisor_i;
        a_sx  = word_i ? {{H{dividend_i[H-1]}}, dividend_i[H-1:0]} : dividend_i;
        a_sgn = signed_i & a_ext[WIDTH-1];
        b_sgn = signed_i & b_ext[WIDTH-1];
        // Magnitudes fit in W bits as unsigned; upper half is zero in word mode.
        a_mag = a_sgn ? -a_ext : a_ext;
        b_mag = b_sgn ? -b_ext : b_ext;
        a_min = word_i ? (dividend_i[H-1:0] == {1'b1, {(H-1){1'b0}}})
                       : (dividend_i == {1'b1, {(WIDTH-1){1'b0}}});
        b_m1  = word_i ? (&divisor_i[H-1:0]) : (&divisor_i);

        special = 1'b0;
        spec_q  = '0;
        spec_r  = '0;
        if (b_mag == '0) begin
            special = 1'b1;
            spec_q  = '1;
            spec_r  = a_sx;
        end else if (signed_i && a_min && b_m1) begin
            special = 1'b1;
            spec_q  = a_sx;
            spec_r  = '0;
        end
`ifdef YSYX_22050058_DIV_FASTPATH_EN
        else if (a_mag < b_mag) begin
            special = 1'b1;
            spec_q  = '0;
            spec_r  = a_sx;
        end
`endif
    end

    // Restoring step chain, STEPS bits per cycle.
    logic [WIDTH-1:0] rem_c [0:STEPS];
    logic [WIDTH-1:0] q_c   [0:STEPS];

    assign rem_c[0] = rem_q;
    assign q_c[0]   = quo_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        ysyx_22050058_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_c[i]),
            .div     (div_q),
            .q_in    (q_c[i]),
            .rem_out (rem_c[i+1]),
            .q_out   (q_c[i+1])
        );
    end

    // Sign fixup; word results are truncated then sign-extended.
    logic [WIDTH-1:0] q_mag, r_mag, q_val, r_val, q_fix, r_fix;

    always_comb begin
        q_mag = word_q ? {{H{1'b0}}, quo_q[H-1:0]} : quo_q;
        r_mag = word_q ? {{H{1'b0}}, rem_q[H-1:0]} : rem_q;
        q_val = q_neg ? -q_mag : q_mag;
        r_val = r_neg ? -r_mag : r_mag;
        q_fix = word_q ? {{H{q_val[H-1]}}, q_val[H-1:0]} : q_val;
        r_fix = word_q ? {{H{r_val[H-1]}}, r_val[H-1:0]} : r_val;
    end

    // Special cases park their final results in quo_q/rem_q and pass through
    // FIX unchanged, giving the one-cycle latency without a second path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            word_q      <= 1'b0;
            bypass      <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        word_q <= word_i;
                        q_neg  <= a_sgn ^ b_sgn;
                        r_neg  <= a_sgn;
                        div_q  <= b_mag;
                        if (special) begin
                            quo_q  <= spec_q;
                            rem_q  <= spec_r;
                            bypass <= 1'b1;
                            state  <= ST_FIX;
                        end else begin
                            quo_q  <= word_i ? {a_mag[H-1:0], {H{1'b0}}} : a_mag;
                            rem_q  <= '0;
                            cnt    <= word_i ? CNT_WORD : CNT_FULL;
                            bypass <= 1'b0;
                            state  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_q <= rem_c[STEPS];
                    quo_q <= q_c[STEPS];
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_FIX: begin
                    quotient_o  <= bypass ? quo_q : q_fix;
                    remainder_o <= bypass ? rem_q : r_fix;
                    state       <= ST_DONE;
                end
                default: begin
                    if (out_ready_i) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_div_iter.sv
module tb_ysyx_22050058_div_iter;

    parameter int STEPS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        sgn;
    logic        wrd;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22050058_div_iter #(.WIDTH(64), .STEPS(STEPS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .signed_i    (sgn),
        .word_i      (wrd),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V division semantics via native arithmetic.
    function automatic void ref_div(input bit sg, input bit wd, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] q,
                                    output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] am, bm;
        bit          spec;
        spec = 1'b0;
        if (wd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = '1; r32 = a32; spec = 1'b1;
            end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0; spec = 1'b1;
            end else if (sg) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q  = {{32{q32[31]}}, q32};
            r  = {{32{r32[31]}}, r32};
            am = {32'h0, (sg && a32[31]) ? -a32 : a32};
            bm = {32'h0, (sg && b32[31]) ? -b32 : b32};
        end else begin
            if (b == 0) begin
                q = '1; r = a; spec = 1'b1;
            end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0; spec = 1'b1;
            end else if (sg) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            am = (sg && a[63]) ? -a : a;
            bm = (sg && b[63]) ? -b : b;
        end
`ifdef YSYX_22050058_DIV_FASTPATH_EN
        if (bm != 0 && am < bm) spec = 1'b1;
`endif
        lat = spec ? 1 : ((wd ? 32 : 64) / STEPS + 1);
    endfunction

    task automatic run_op(input string tag, input bit sg, input bit wd, input logic [63:0] a,
                          input logic [63:0] b, input int stall);
        logic [63:0] eq, er;
        int          elat;
        int          cyc;
        ref_div(sg, wd, a, b, eq, er, elat);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b1; sgn = sg; wrd = wd; dividend = a; divisor = b;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must not matter.
        in_valid = 1'b0; sgn = 1'($urandom); wrd = 1'($urandom);
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 200);
        check({tag, ".latency"}, 64'(cyc), 64'(elat));
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".stall_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".stall_q"}, quotient, eq);
            check({tag, ".stall_r"}, remainder, er);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".released"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [63:0] rnd_val(input int kind);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case (kind)
            0: return '0;
            1: return '1;
            2: return 64'($urandom_range(1, 15));
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_8000_0000;
            5: return v >> $urandom_range(0, 63);
            6: return {32'h0, v[31:0]};
            7: return -(64'($urandom_range(1, 15)));
            default: return v;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sgn = 1'b0; wrd = 1'b0; dividend = '0; divisor = '0;
        #3;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.quotient", quotient, 64'd0);
        check("reset.remainder", remainder, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 0);
        run_op("s-7_2", 1'b1, 1'b0, -64'd7, 64'd2, 0);
        run_op("s7_-2", 1'b1, 1'b0, 64'd7, -64'd2, 0);
        run_op("div0", 1'b0, 1'b0, 64'h1234, 64'd0, 0);
        run_op("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("w_min_1", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 0);
        run_op("w_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 0);
        run_op("wu_div0", 1'b0, 1'b1, 64'h0000_0000_9000_0001, 64'h5_0000_0000, 0);
        run_op("small3_10", 1'b0, 1'b0, 64'd3, 64'd10, 0);
        run_op("stall", 1'b1, 1'b0, -64'd1000, 64'd3, 10);

        // Flush while busy: back to idle, no result ever appears.
        @(negedge clk);
        in_valid = 1'b1; sgn = 1'b0; wrd = 1'b0; dividend = 64'd100; divisor = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush.in_ready", 64'(in_ready), 64'd1);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= out_valid; end
        check("flush.no_result", 64'(seen), 64'd0);

        // Flush coinciding with a handshake drops the request.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; dividend = 64'd5; divisor = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_hs.in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk); #1;
        check("flush_hs.out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-operation.
        run_op("pre_rst", 1'b0, 1'b0, 64'd999, 64'd10, 0);
        @(negedge clk);
        in_valid = 1'b1; dividend = 64'd12345; divisor = 64'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.in_ready", 64'(in_ready), 64'd1);
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.quotient", quotient, 64'd0);
        check("arst.remainder", remainder, 64'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (70) begin @(posedge clk); #1; seen |= out_valid; end
        check("arst.no_result", 64'(seen), 64'd0);

        for (int n = 0; n < 200; n++) begin
            logic [63:0] a, b;
            a = rnd_val($urandom_range(0, 10));
            b = rnd_val($urandom_range(0, 12));
            run_op("rand", 1'($urandom), 1'($urandom), a, b, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
